// File: rtl/wb_master_arb2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_master_arb2_pkg                                                   |
// | Shared types and defaults for the two-requester Wishbone master.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_master_arb2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 0 = requester 0, 1 = requester 1
  typedef logic owner_t;

  localparam int          DEF_AW      = 32;
  localparam int          DEF_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  function automatic owner_t owner_of(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_master_arb2_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2                                                             |
// | Combinational two-way round-robin picker; returns a one-hot grant.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick2
  import wb_master_arb2_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // On a tie the requester that did not own the bus last time wins.
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_master_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_master_arb2                                                       |
// | Round-robin two-requester Wishbone B4 classic single-transfer master |
// | with a programmable ACK timeout.                                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_master_arb2
  import wb_master_arb2_pkg::*;
#(
  parameter int          AW      = DEF_AW,
  parameter int          DW      = DEF_DW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          CLK_I,
  input  logic          RST_I,

  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] adr0_i,
  input  logic [DW-1:0] dat0_i,
  output logic          done0_o,
  output logic          err0_o,
  output logic [DW-1:0] rdat0_o,

  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] adr1_i,
  input  logic [DW-1:0] dat1_i,
  output logic          done1_o,
  output logic          err1_o,
  output logic [DW-1:0] rdat1_o,

  output logic [1:0]    gnt_o,

  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  output logic [AW-1:0] ADR_O,
  output logic [DW-1:0] DAT_O,
  input  logic [DW-1:0] DAT_I,
  input  logic          ACK_I
);

  localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_SAT  = CW'(TIMEOUT);
  localparam bit             TO_EN    = (TIMEOUT != 0);

  state_e          state_q, state_d;
  owner_t          last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [1:0]      gnt_q,   gnt_d;
  logic            cyc_q,   cyc_d;
  logic            we_q,    we_d;
  logic [AW-1:0]   adr_q,   adr_d;
  logic [DW-1:0]   dat_q,   dat_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic            err0_q,  err0_d;
  logic            err1_q,  err1_d;
  logic [DW-1:0]   rdat0_q, rdat0_d;
  logic [DW-1:0]   rdat1_q, rdat1_d;

  logic [1:0]      pick;
  owner_t          owner;
  logic [CW-1:0]   cnt_inc;
  logic            bus_end;

  rr_pick2 u_pick (
    .req_i  ({req1_i, req0_i}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign owner   = owner_of(gnt_q);
  assign cnt_inc = (cnt_q != CNT_SAT) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
    bus_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick != 2'b00) begin
          gnt_d   = pick;
          last_d  = pick[1];
          cyc_d   = 1'b1;
          we_d    = pick[1] ? we1_i  : we0_i;
          adr_d   = pick[1] ? adr1_i : adr0_i;
          dat_d   = pick[1] ? dat1_i : dat0_i;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        // ACK is tested first so it wins over a timeout on the same edge.
        if (ACK_I) begin
          bus_end = 1'b1;
          if (owner) begin
            done1_d = 1'b1;
            if (!we_q) rdat1_d = DAT_I;
          end else begin
            done0_d = 1'b1;
            if (!we_q) rdat0_d = DAT_I;
          end
        end else begin
          cnt_d = cnt_inc;
          if (TO_EN && (cnt_inc == CNT_SAT)) begin
            bus_end = 1'b1;
            if (owner) err1_d = 1'b1;
            else       err0_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus_end) begin
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      adr_d   = '0;
      dat_d   = '0;
      gnt_d   = 2'b00;
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
    end
  end

  assign CYC_O   = cyc_q;
  assign STB_O   = cyc_q;
  assign WE_O    = we_q;
  assign ADR_O   = adr_q;
  assign DAT_O   = dat_q;
  assign gnt_o   = gnt_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign err0_o  = err0_q;
  assign err1_o  = err1_q;
  assign rdat0_o = rdat0_q;
  assign rdat1_o = rdat1_q;

endmodule
`default_nettype wire
